// File: rtl/ysyx_23060201_mem_arbiter.sv
// Two-master (IFU/LSU) round-robin arbiter in front of the single data-memory port.
// One outstanding transaction; the request is latched at handshake and replayed to memory until accepted.
module ysyx_23060201_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_raddr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [7:0]            lsu_wmask,
  output logic                  lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_e                  state_q;
  logic                    owner_q;
  logic                    last_q;
  logic                    req_valid_q;
  logic                    wen_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [7:0]              wmask_q;

  logic                    idle;
  logic                    grant_ifu;
  logic                    grant_lsu;
  logic                    rsp_fire;
  logic [DATA_WIDTH-1:0]   rsp_data;

  // On a tie the master that was not granted last wins; a lone requester always wins.
  assign idle      = (state_q == S_IDLE);
  assign grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_q == OWN_LSU));
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_q == OWN_IFU));

  assign ifu_req_ready = idle && grant_ifu;
  assign lsu_req_ready = idle && grant_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IFU;
      last_q      <= OWN_IFU;
      req_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ifu_req_ready) begin
            owner_q     <= OWN_IFU;
            last_q      <= OWN_IFU;
            wen_q       <= 1'b0;
            addr_q      <= ifu_raddr;
            wdata_q     <= '0;
            wmask_q     <= '0;
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end else if (lsu_req_ready) begin
            owner_q     <= OWN_LSU;
            last_q      <= OWN_LSU;
            wen_q       <= lsu_wen;
            addr_q      <= lsu_addr;
            wdata_q     <= lsu_wdata;
            wmask_q     <= lsu_wmask;
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_wen       = wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Responses outside WAIT are stray and never reach a master.
  assign rsp_fire = (state_q == S_WAIT) && mem_rsp_valid;
  assign rsp_data = wen_q ? '0 : mem_rdata;

  assign ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
  assign ifu_rdata     = ifu_rsp_valid ? rsp_data : '0;
  assign lsu_rdata     = lsu_rsp_valid ? rsp_data : '0;

endmodule
